cpu_sram_bridge: RTL and testbench
==================================

// Module: cpu_sram_bridge
//
// PURPOSE
//   Bridges the 6502 core bus to spi_sram_master, sitting directly upstream of it.
//   - Extends the 16-bit CPU address with a bank value to form the 24-bit SRAM address.
//   - Posts writes so the CPU does not wait for them.
//   - Holds a 1-entry read cache; a hit returns data without an SPI transaction.
//   - Stalls the CPU through cpu_rdy whenever an SPI transaction must complete first.
//
// PARAMETERS
//   CPU_AW    16  CPU address width
//   MEM_AW    24  SRAM address width; bank width is MEM_AW-CPU_AW
//   CACHE_EN  1   0 disables the read cache: every read misses
//
// PORTS
//   clk        in   1                single clock, rising edge
//   rst_n      in   1                asynchronous, active-low reset
//   en         in   1                clock enable; all state advances only when en=1
//   bank       in   MEM_AW-CPU_AW    upper SRAM address bits, sampled when a request is accepted
//   cpu_req    in   1                CPU access request valid
//   cpu_addr   in   CPU_AW           CPU address
//   cpu_we     in   1                1 = write, 0 = read
//   cpu_do     in   8                CPU write data
//   cpu_di     out  8                read data returned to the CPU
//   cpu_rdy    out  1                1 = request accepted this cycle, cpu_di valid
//   mem_ready  in   1                ready output of spi_sram_master
//   mem_addr   out  MEM_AW           {bank, cpu_addr}, registered
//   mem_en     out  1                transaction request to the master
//   mem_wr     out  1                1 = write transaction
//   mem_wdata  out  8                write data to the master
//   mem_rdata  in   8                read data from the master
//
// BEHAVIOUR
//   - Reset values: cpu_rdy=1, cpu_di=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
//     Cache is invalid and the FSM is in IDLE.
//   - Request acceptance: on the edge where en && cpu_req && cpu_rdy.
//     The request is registered as {bank, cpu_addr, cpu_we, cpu_do}.
//   - Read hit: cache valid and tag == {bank, cpu_addr}. cpu_di takes the cached byte on the next edge.
//     cpu_rdy stays 1, giving 1-cycle latency.
//   - Read miss: cpu_rdy=0 from the next cycle until the transaction completes.
//     On completion, cpu_di and the cache both take mem_rdata and cpu_rdy returns to 1.
//   - Write: posted. cpu_rdy stays 1.
//     If the cache tag matches, the cached byte takes cpu_do; otherwise the cache is unchanged.
//   - Pending posted write: any new CPU request drops cpu_rdy to 0 until the write completes.
//     The new request is then issued normally. At most one write is outstanding.
//   - FSM: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
//     - ISSUE: mem_en=1, held until an edge with en && mem_ready=1.
//     - BUSY: wait for mem_ready=0 on an en edge (the master has started).
//     - DONE: wait for mem_ready=1 on an en edge. A read captures mem_rdata on that edge.
//       Go to IDLE, or straight to ISSUE if a request is queued.
//   - mem_en is deasserted on the edge that leaves ISSUE. It is never asserted outside ISSUE.
//   - mem_addr, mem_wr and mem_wdata are stable from ISSUE entry until DONE exit.
//   - en=0: everything freezes, including cache updates and the handshake.
//   - Reset mid-transaction: returns to reset values at once and the cache is invalidated.
//     spi_sram_master shares the same reset, so no half-transaction survives.
//   - CACHE_EN=0: the hit path is never taken and the tag/valid logic is removed.
//
// STRUCTURE
//   - spi_sram_pkg holds: bridge_state_t enum (IDLE, ISSUE, BUSY, DONE); localparams
//     MEM_AW_DEF=24 and CPU_AW_DEF=16.
//   - One sub-module, bridge_rdcache: 1-entry tag/valid/data with lookup, fill,
//     write-update and invalidate ports.
//   - The FSM and posted-write queue register live in the top module.
//
// TESTING
//   - Read miss: bank=8'h01, read 16'h1234, model returns 8'hA5.
//     -> mem_addr=24'h011234, mem_wr=0; cpu_rdy low until done; cpu_di=8'hA5.
//   - Read hit: repeat the read of 16'h1234 after the miss.
//     -> no mem_en pulse; cpu_rdy stays 1; cpu_di=8'hA5 one cycle later.
//   - Posted write then read: write 8'h3C to 16'h1234, then read 16'h2000 next cycle.
//     -> write issued with mem_wr=1, mem_wdata=8'h3C; cpu_rdy=0 until the write is done;
//        the read is issued afterwards; a later read of 16'h1234 hits and returns 8'h3C.
//   - Bank change: read 16'h1234 with bank=8'h02.
//     -> miss; mem_addr=24'h021234.
//   - en gating: hold en=0 for 5 cycles during BUSY.
//     -> state, mem_en and cpu_rdy unchanged; the transaction completes after en returns.
//   - Async reset: assert rst_n=0 mid-DONE.
//     -> cpu_rdy=1, mem_en=0 immediately; the next read of a prior address misses.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared types and default widths for the CPU-to-SPI-SRAM bridge.
package spi_sram_pkg;

    localparam int unsigned MEM_AW_DEF = 24;
    localparam int unsigned CPU_AW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/bridge_rdcache.sv
// Single-entry read cache: tag/valid/data with lookup, fill, write-update and invalidate.
module bridge_rdcache #(
    parameter int unsigned AW = 24,
    parameter bit          EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [AW-1:0] i_lk_addr,
    output logic          o_hit_c,
    output logic [7:0]    o_data,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [7:0]    i_fill_data,
    input  logic          i_upd,
    input  logic [AW-1:0] i_upd_addr,
    input  logic [7:0]    i_upd_data,
    input  logic          i_inv
);

    generate
        if (EN) begin : g_cache
            logic          r_valid;
            logic [AW-1:0] r_tag;
            logic [7:0]    r_data;

            // Entry update: invalidate beats fill, fill beats write-update on a tag match
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                    r_data  <= '0;
                end else if (i_en) begin
                    if (i_inv) begin
                        r_valid <= 1'b0;
                    end else if (i_fill) begin
                        r_valid <= 1'b1;
                        r_tag   <= i_fill_addr;
                        r_data  <= i_fill_data;
                    end else if (i_upd && r_valid && (r_tag == i_upd_addr)) begin
                        r_data  <= i_upd_data;
                    end
                end
            end

            assign o_hit_c = r_valid && (r_tag == i_lk_addr);
            assign o_data  = r_data;
        end else begin : g_nocache
            assign o_hit_c = 1'b0;
            assign o_data  = 8'h00;
        end
    endgenerate

endmodule

// File: rtl/cpu_sram_bridge.sv
// 6502 bus to spi_sram_master bridge: bank extension, posted writes, 1-entry read cache.
module cpu_sram_bridge
    import spi_sram_pkg::*;
#(
    parameter int unsigned CPU_AW   = CPU_AW_DEF,
    parameter int unsigned MEM_AW   = MEM_AW_DEF,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [MEM_AW-CPU_AW-1:0] bank,
    input  logic                     cpu_req,
    input  logic [CPU_AW-1:0]        cpu_addr,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_do,
    output logic [7:0]               cpu_di,
    output logic                     cpu_rdy,
    input  logic                     mem_ready,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata
);

    bridge_state_t       r_state;
    logic                r_q_valid;
    logic [MEM_AW-1:0]   r_q_addr;
    logic                r_q_we;
    logic [7:0]          r_q_wdata;

    logic                w_accept;
    logic [MEM_AW-1:0]   w_cpu_addr;
    logic [MEM_AW-1:0]   w_src_addr;
    logic                w_src_we;
    logic [7:0]          w_src_wdata;
    logic                w_done;
    logic                w_go;
    logic                w_hit;
    logic [7:0]          w_hit_data;
    logic                w_fill;
    logic                w_upd;

    // Request sources: a queued request always takes precedence over the live CPU bus
    assign w_accept    = en && cpu_req && cpu_rdy;
    assign w_cpu_addr  = {bank, cpu_addr};
    assign w_src_addr  = r_q_valid ? r_q_addr  : w_cpu_addr;
    assign w_src_we    = r_q_valid ? r_q_we    : cpu_we;
    assign w_src_wdata = r_q_valid ? r_q_wdata : cpu_do;
    assign w_done      = (r_state == DONE) && mem_ready;
    assign w_go        = ((r_state == IDLE) && w_accept) || (w_done && (r_q_valid || w_accept));
    assign w_fill      = en && w_done && !mem_wr;
    assign w_upd       = w_accept && cpu_we;

    bridge_rdcache #(
        .AW (MEM_AW),
        .EN (CACHE_EN)
    ) u_rdcache (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (en),
        .i_lk_addr   (w_src_addr),
        .o_hit_c     (w_hit),
        .o_data      (w_hit_data),
        .i_fill      (w_fill),
        .i_fill_addr (mem_addr),
        .i_fill_data (mem_rdata),
        .i_upd       (w_upd),
        .i_upd_addr  (w_cpu_addr),
        .i_upd_data  (cpu_do),
        .i_inv       (1'b0)
    );

    // Transaction FSM, request queue and all registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_q_valid <= 1'b0;
            r_q_addr  <= '0;
            r_q_we    <= 1'b0;
            r_q_wdata <= 8'h00;
            cpu_di    <= 8'h00;
            cpu_rdy   <= 1'b1;
            mem_addr  <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 8'h00;
        end else if (en) begin
            // A request arriving behind an outstanding write waits in the queue
            if (w_go) begin
                r_q_valid <= 1'b0;
            end else if (w_accept) begin
                r_q_valid <= 1'b1;
                r_q_addr  <= w_cpu_addr;
                r_q_we    <= cpu_we;
                r_q_wdata <= cpu_do;
                cpu_rdy   <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_en  <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mem_ready) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (mem_ready) begin
                        r_state <= IDLE;
                        if (!mem_wr) begin
                            cpu_di  <= mem_rdata;
                            cpu_rdy <= 1'b1;
                        end
                    end
                end
            endcase

            // Dispatch overrides the plain state advance above
            if (w_go) begin
                if (!w_src_we && w_hit) begin
                    cpu_di  <= w_hit_data;
                    cpu_rdy <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    mem_addr  <= w_src_addr;
                    mem_wr    <= w_src_we;
                    mem_wdata <= w_src_wdata;
                    mem_en    <= 1'b1;
                    cpu_rdy   <= w_src_we;
                    r_state   <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Randomized self-checking bench for cpu_sram_bridge with an SPI SRAM master model.
module tb_cpu_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  bank;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        mem_ready;
    logic [23:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    cpu_sram_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bank      (bank),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_do    (cpu_do),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Initial SRAM contents, shared by the memory model and the reference
    function automatic logic [7:0] seed_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Reference: sequential byte memory plus a one-entry "last read miss" tag
    logic [7:0]  ref_mem [int];
    bit          ref_cv = 1'b0;
    logic [23:0] ref_tag = 24'h0;

    task automatic model_req(input bit we, input logic [7:0] b, input logic [15:0] a,
                             input logic [7:0] d, output logic [7:0] exp, output bit miss);
        logic [23:0] full;
        full = {b, a};
        exp  = 8'h00;
        miss = 1'b0;
        if (we) begin
            ref_mem[int'(full)] = d;
        end else begin
            exp  = ref_mem.exists(int'(full)) ? ref_mem[int'(full)] : seed_byte(full);
            miss = !(ref_cv && (ref_tag == full));
            if (miss) begin
                ref_cv  = 1'b1;
                ref_tag = full;
            end
        end
    endtask

    // SPI SRAM master model: ready drops after accepting, rises with read data
    logic [7:0] s_mem [int];
    int s_rd_cnt = 0;
    bit s_busy = 1'b0;
    int lat_fix = 0;
    int lat_max = 3;

    initial begin : slave
        logic        s_men;
        logic [23:0] s_addr;
        logic        s_wr;
        logic [7:0]  s_wd;
        logic [23:0] c_addr;
        logic        c_wr;
        logic [7:0]  c_wd;
        int          lowcnt;
        mem_ready = 1'b1;
        mem_rdata = 8'h00;
        c_addr = 24'h0;
        c_wr   = 1'b0;
        c_wd   = 8'h00;
        lowcnt = 0;
        forever begin
            @(negedge clk);
            s_men  = mem_en;
            s_addr = mem_addr;
            s_wr   = mem_wr;
            s_wd   = mem_wdata;
            if (s_busy && rst_n) begin
                check_eq("mem_en_while_busy", 32'(s_men), 32'd0);
                check_eq("mem_addr_stable", 32'(s_addr), 32'(c_addr));
                check_eq("mem_wr_stable", 32'(s_wr), 32'(c_wr));
                check_eq("mem_wdata_stable", 32'(s_wd), 32'(c_wd));
            end
            @(posedge clk);
            if (!rst_n) begin
                s_busy = 1'b0;
                #1 mem_ready = 1'b1;
            end else if (en) begin
                if (!s_busy) begin
                    if (s_men && mem_ready) begin
                        c_addr = s_addr;
                        c_wr   = s_wr;
                        c_wd   = s_wd;
                        s_busy = 1'b1;
                        lowcnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, lat_max));
                        if (c_wr) s_mem[int'(c_addr)] = c_wd;
                        else      s_rd_cnt++;
                        #1 mem_ready = 1'b0;
                    end
                end else if (!mem_ready) begin
                    lowcnt--;
                    if (lowcnt == 0) begin
                        #1;
                        if (!c_wr)
                            mem_rdata = s_mem.exists(int'(c_addr)) ? s_mem[int'(c_addr)] : seed_byte(c_addr);
                        mem_ready = 1'b1;
                    end
                end else begin
                    s_busy = 1'b0;
                end
            end
        end
    end

    bit rand_en = 1'b0;

    task automatic tick();
        @(negedge clk);
        en = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    endtask

    // Present a request and hold it until accepted; returns at the negedge after acceptance
    task automatic issue(input bit we, input logic [7:0] b, input logic [15:0] a,
                         input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        cpu_req  = 1'b1;
        cpu_we   = we;
        bank     = b;
        cpu_addr = a;
        cpu_do   = d;
        while (!(cpu_rdy && en) && n < 1000) begin
            tick();
            n++;
        end
        ok = cpu_rdy && en;
        if (!ok) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            cpu_req = 1'b0;
        end else begin
            @(posedge clk);
            tick();
            cpu_req = 1'b0;
        end
    endtask

    task automatic wait_read(input string tag, input logic [7:0] exp, input bit miss, input int snap);
        int n;
        n = 0;
        while (!cpu_rdy && n < 2000) begin
            tick();
            n++;
        end
        check_eq({tag, "_rdy"}, 32'(cpu_rdy), 32'd1);
        check_eq({tag, "_data"}, 32'(cpu_di), 32'(exp));
        check_eq({tag, "_spi_reads"}, 32'(s_rd_cnt - snap), 32'(miss));
    endtask

    task automatic do_req(input bit we, input logic [7:0] b, input logic [15:0] a,
                          input logic [7:0] d, input string tag);
        bit         ok;
        int         snap;
        logic [7:0] exp;
        bit         miss;
        snap = s_rd_cnt;
        issue(we, b, a, d, ok);
        if (ok) begin
            model_req(we, b, a, d, exp, miss);
            if (!we) wait_read(tag, exp, miss, snap);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        bit         ok;
        int         snap;
        logic [7:0] exp;
        bit         miss;

        rst_n = 1'b0; en = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        bank = 8'h00; cpu_addr = 16'h0; cpu_do = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        check_eq("rst_cpu_di", 32'(cpu_di), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Read miss at bank 01
        s_mem[int'(24'h011234)]   = 8'hA5;
        ref_mem[int'(24'h011234)] = 8'hA5;
        snap = s_rd_cnt;
        issue(1'b0, 8'h01, 16'h1234, 8'h00, ok);
        model_req(1'b0, 8'h01, 16'h1234, 8'h00, exp, miss);
        check_eq("miss_rdy_low", 32'(cpu_rdy), 32'd0);
        check_eq("miss_mem_en", 32'(mem_en), 32'd1);
        check_eq("miss_mem_addr", 32'(mem_addr), 32'h011234);
        check_eq("miss_mem_wr", 32'(mem_wr), 32'd0);
        wait_read("miss", exp, miss, snap);
        check_eq("miss_data_a5", 32'(cpu_di), 32'hA5);

        // Read hit of the same address
        snap = s_rd_cnt;
        issue(1'b0, 8'h01, 16'h1234, 8'h00, ok);
        model_req(1'b0, 8'h01, 16'h1234, 8'h00, exp, miss);
        check_eq("hit_rdy", 32'(cpu_rdy), 32'd1);
        check_eq("hit_no_mem_en", 32'(mem_en), 32'd0);
        check_eq("hit_data_a5", 32'(cpu_di), 32'hA5);
        wait_read("hit", exp, miss, snap);

        // Posted write then an immediate read that must wait behind it
        issue(1'b1, 8'h01, 16'h1234, 8'h3C, ok);
        model_req(1'b1, 8'h01, 16'h1234, 8'h3C, exp, miss);
        check_eq("wr_rdy_stays", 32'(cpu_rdy), 32'd1);
        check_eq("wr_mem_en", 32'(mem_en), 32'd1);
        check_eq("wr_mem_wr", 32'(mem_wr), 32'd1);
        check_eq("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
        snap = s_rd_cnt;
        issue(1'b0, 8'h01, 16'h2000, 8'h00, ok);
        model_req(1'b0, 8'h01, 16'h2000, 8'h00, exp, miss);
        check_eq("queued_rdy_low", 32'(cpu_rdy), 32'd0);
        wait_read("rd_after_wr", exp, miss, snap);
        do_req(1'b0, 8'h01, 16'h1234, 8'h00, "reread_1234");
        check_eq("reread_data_3c", 32'(cpu_di), 32'h3C);

        // Bank change
        snap = s_rd_cnt;
        issue(1'b0, 8'h02, 16'h1234, 8'h00, ok);
        model_req(1'b0, 8'h02, 16'h1234, 8'h00, exp, miss);
        check_eq("bank2_mem_addr", 32'(mem_addr), 32'h021234);
        wait_read("bank2", exp, miss, snap);

        // Clock-enable freeze during BUSY
        snap = s_rd_cnt;
        issue(1'b0, 8'h02, 16'h4444, 8'h00, ok);
        model_req(1'b0, 8'h02, 16'h4444, 8'h00, exp, miss);
        tick();
        check_eq("busy_mem_en", 32'(mem_en), 32'd0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("frozen_mem_en", 32'(mem_en), 32'd0);
            check_eq("frozen_rdy", 32'(cpu_rdy), 32'd0);
        end
        en = 1'b1;
        wait_read("en_gate", exp, miss, snap);

        // Asynchronous reset while waiting in DONE
        lat_fix = 8;
        issue(1'b0, 8'h02, 16'h5555, 8'h00, ok);
        tick();
        tick();
        tick();
        check_eq("pre_rst_rdy_low", 32'(cpu_rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        check_eq("arst_mem_en", 32'(mem_en), 32'd0);
        check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_cpu_di", 32'(cpu_di), 32'd0);
        ref_cv  = 1'b0;
        lat_fix = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        do_req(1'b0, 8'h02, 16'h4444, 8'h00, "post_rst");

        // Randomized traffic with en toggling
        rand_en = 1'b1;
        lat_max = 4;
        for (int i = 0; i < 300; i++) begin
            logic       we;
            logic [7:0] b;
            logic [15:0] a;
            logic [7:0] d;
            we = ($urandom_range(0, 2) == 0);
            b  = 8'($urandom_range(0, 1));
            a  = 16'h1230 + 16'($urandom_range(0, 5));
            d  = 8'($urandom);
            do_req(we, b, a, d, "rnd");
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_en = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
